ram_writer: RTL and testbench
=============================

Name: ram_writer

Overview:
- Write side of the frame RAM in the VGA serial display path.
- Takes the byte stream from the UART receiver and packs it into RAM_WIDTH-bit words, MSB first.
- Writes the words to sequential RAM addresses, from 0 to the last word of one frame.
- Sits between the serial receiver and the frame RAM write port; the display-side reader consumes the same RAM on the other port.

Parameters:
- RAM_WIDTH, 32: RAM word width in bits; must be a multiple of 8.
- N_BITS, 480*360*24: total bits per frame; RAM_DEPTH = N_BITS/RAM_WIDTH words.
- TIMEOUT_CYCLES, 100000: maximum idle clk cycles allowed between bytes inside a partially filled word.
- Derived localparams: BYTES_PER_WORD = RAM_WIDTH/8; MAX_ADRESS = RAM_DEPTH-1; ADRESS_BITS = $clog2(RAM_DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; valid only while rx_ready is high.
- rx_ready  in  1  single-cycle strobe: rx_data holds a new byte.
- frame_start  in  1  single-cycle strobe: begin or restart a frame at address 0.
- adress  out  ADRESS_BITS  RAM write address.
- data_out  out  RAM_WIDTH  RAM write data.
- write_en  out  1  RAM write strobe, one cycle per word.
- busy  out  1  high while in state RECEIVE.
- frame_done  out  1  one-cycle pulse coincident with the write of word MAX_ADRESS.
- timeout_err  out  1  one-cycle pulse when a partial word is discarded on timeout.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; all outputs 0, including adress, data_out, write_en, busy, frame_done, timeout_err; byte_cnt=0, shift buffer=0, timeout counter=0.
- States: IDLE, RECEIVE.
- IDLE:
  - rx_ready is ignored.
  - frame_start -> RECEIVE, with adress=0 and byte_cnt=0.
- RECEIVE, byte intake:
  - Each rx_ready shifts rx_data into the low byte of the buffer; earlier bytes move up, so the first byte ends in bits [RAM_WIDTH-1:RAM_WIDTH-8].
  - byte_cnt increments on each accepted byte.
- RECEIVE, word completion:
  - The BYTES_PER_WORD-th byte is accepted at edge N.
  - After edge N+1: data_out = packed word, write_en=1 for exactly one cycle, adress = current word address.
  - In that same cycle the buffer and byte_cnt are already cleared, so an rx_ready in that cycle is byte 0 of the next word. No bytes are lost.
  - Address increment: adress advances by 1 the cycle after write_en.
  - Last word: if adress==MAX_ADRESS, frame_done pulses together with write_en. The state then returns to IDLE and adress wraps to 0. No further writes occur until the next frame_start.
- Timeout:
  - A counter runs while in RECEIVE with byte_cnt!=0; it clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES: byte_cnt and the buffer are cleared, timeout_err pulses for 1 cycle, adress is unchanged, and the state stays RECEIVE.
  - The counter is inactive when byte_cnt==0; waiting between words is unbounded.
- frame_start in RECEIVE: restarts the frame. adress=0, the partial word is discarded, no write and no error pulse.
- frame_start and rx_ready in the same cycle (either state): frame_start takes priority, and that byte is taken as byte 0 of the new frame.
- Timeout and rx_ready in the same cycle: the byte wins, the counter clears, and no error is flagged.
- Latency: 1 clk from accepting the last byte of a word to write_en.
- Widths: the address comparison uses ADRESS_BITS; byte_cnt is $clog2(BYTES_PER_WORD)+1 bits; the timeout counter is $clog2(TIMEOUT_CYCLES+1) bits.
- Reset mid-word or mid-frame: all progress is discarded immediately.

Decomposition:
- Package vga_serial_pkg holds:
  - the state enum (IDLE, RECEIVE);
  - BYTE_W=8;
  - the default frame constants (480, 360, 24 bpp);
  - a function computing RAM_DEPTH from N_BITS and RAM_WIDTH, shared with the display-side reader.
- Sub-module byte_packer (parameter RAM_WIDTH): shift buffer, byte_cnt and word_full flag, with a clear input.
- ram_writer contains the FSM, address counter, timeout counter and output registers.

Test Plan (bench params RAM_WIDTH=32, N_BITS=128 giving 4 words, TIMEOUT_CYCLES=20):
- Reset, then frame_start, then bytes 0x11,0x22,0x33,0x44 with 5-cycle gaps -> one write_en pulse, data_out=0x11223344, adress=0; adress=1 the next cycle.
- Full frame of 16 bytes 0x00..0x0F -> 4 writes (0x00010203 @0 … 0x0C0D0E0F @3); frame_done coincides with the @3 write; state IDLE, adress=0; a 17th byte produces no write.
- frame_start, bytes 0xAA,0xBB, then 20 idle cycles -> timeout_err pulses once, no write; then 0x01..0x04 -> write 0x01020304 @0.
- 4th byte, then a back-to-back rx_ready (0x55) in the write_en cycle -> the word is written correctly and 0x55 becomes the MSB of the next word.
- frame_start after 2 words plus 2 bytes, with a simultaneous rx_ready carrying 0x99 -> no write of the partial word, no error; the next 3 bytes 0x98,0x97,0x96 produce write 0x99989796 @0.
- rst driven low asynchronously mid-word, between clock edges -> all outputs 0 immediately; after release, bytes before frame_start are ignored.

Source files
------------

// File: rtl/vga_serial_pkg.sv
// Shared definitions for the VGA serial display path: writer FSM states,
// byte width, default frame geometry, and the RAM depth calculation that
// the writer and the display-side reader must agree on.
package vga_serial_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RECEIVE = 1'b1
  } state_t;

  localparam int BYTE_W     = 8;
  localparam int FRAME_W    = 480;
  localparam int FRAME_H    = 360;
  localparam int FRAME_BPP  = 24;
  localparam int FRAME_BITS = FRAME_W * FRAME_H * FRAME_BPP;

  // Number of RAM words needed to hold one frame.
  function automatic int ram_depth(input int n_bits, input int ram_width);
    return n_bits / ram_width;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream MSB-first into a RAM_WIDTH-bit word. A clear that
// coincides with a load starts a fresh word holding that byte, so a byte
// arriving in the same cycle as a word hand-off is never lost.
module byte_packer
  import vga_serial_pkg::*;
#(
  parameter  int RAM_WIDTH = 32,
  localparam int BPW       = RAM_WIDTH / BYTE_W,
  localparam int CNT_W     = $clog2(BPW) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic [BYTE_W-1:0]    i_byte,
  output logic [RAM_WIDTH-1:0] o_word,
  output logic [CNT_W-1:0]     o_byte_cnt,
  output logic                 o_word_full
);

  logic [RAM_WIDTH-1:0] r_buf;
  logic [CNT_W-1:0]     r_cnt;

  // Shift buffer and byte counter; earlier bytes move toward the MSB.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_buf <= i_load ? RAM_WIDTH'(i_byte) : '0;
      r_cnt <= i_load ? CNT_W'(1) : '0;
    end else if (i_load) begin
      r_buf <= (r_buf << BYTE_W) | RAM_WIDTH'(i_byte);
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_word      = r_buf;
  assign o_byte_cnt  = r_cnt;
  assign o_word_full = (r_cnt == CNT_W'(BPW));

endmodule

// File: rtl/ram_writer.sv
// Write side of the frame RAM: turns UART bytes into RAM words, writes them
// to sequential addresses for one frame, and drops stalled partial words.
module ram_writer
  import vga_serial_pkg::*;
#(
  parameter  int RAM_WIDTH      = 32,
  parameter  int N_BITS         = FRAME_BITS,
  parameter  int TIMEOUT_CYCLES = 100000,
  localparam int BYTES_PER_WORD = RAM_WIDTH / BYTE_W,
  localparam int RAM_DEPTH      = ram_depth(N_BITS, RAM_WIDTH),
  localparam int MAX_ADRESS     = RAM_DEPTH - 1,
  localparam int ADRESS_BITS    = $clog2(RAM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BYTE_W-1:0]      rx_data,
  input  logic                   rx_ready,
  input  logic                   frame_start,
  output logic [ADRESS_BITS-1:0] adress,
  output logic [RAM_WIDTH-1:0]   data_out,
  output logic                   write_en,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   timeout_err
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADRESS_BITS-1:0] LAST_ADR = ADRESS_BITS'(MAX_ADRESS);
  localparam logic [TMO_W-1:0]       TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t                 r_state, w_state_nxt;
  logic [ADRESS_BITS-1:0] r_adress, w_adress_inc, w_adress_cur;
  logic [RAM_WIDTH-1:0]   r_data_out, w_word;
  logic                   r_write_en, r_frame_done, r_timeout_err;
  logic [TMO_W-1:0]       r_tmo_cnt;
  logic [CNT_W-1:0]       w_byte_cnt;
  logic                   w_word_full;
  logic                   w_pk_clear, w_pk_load;
  logic                   w_write, w_last, w_timeout, w_tmo_run;

  byte_packer #(.RAM_WIDTH(RAM_WIDTH)) u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_pk_clear),
    .i_load      (w_pk_load),
    .i_byte      (rx_data),
    .o_word      (w_word),
    .o_byte_cnt  (w_byte_cnt),
    .o_word_full (w_word_full)
  );

  // The address increments one cycle after each write, so the word being
  // completed now targets the post-increment address if a write is pending.
  assign w_adress_inc = (r_adress == LAST_ADR) ? '0 : r_adress + ADRESS_BITS'(1);
  assign w_adress_cur = r_write_en ? w_adress_inc : r_adress;

  // Next state and per-cycle control: frame_start beats everything, a
  // finished word beats a new byte, a new byte beats the timeout.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    w_state_nxt = r_state;
    w_pk_clear  = 1'b0;
    w_pk_load   = 1'b0;
    w_write     = 1'b0;
    w_last      = 1'b0;
    w_timeout   = 1'b0;
    w_tmo_run   = 1'b0;
    case (r_state)
      IDLE: begin
        w_pk_clear = 1'b1;
        if (frame_start) begin
          w_state_nxt = RECEIVE;
          w_pk_load   = rx_ready;
        end
      end
      RECEIVE: begin
        if (frame_start) begin
          w_pk_clear = 1'b1;
          w_pk_load  = rx_ready;
        end else if (w_word_full) begin
          w_write    = 1'b1;
          w_pk_clear = 1'b1;
          if (w_adress_cur == LAST_ADR) begin
            w_last      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_pk_load = rx_ready;
          end
        end else if (rx_ready) begin
          w_pk_load = 1'b1;
        end else if (w_byte_cnt != '0) begin
          if (r_tmo_cnt == TMO_LAST) begin
            w_timeout  = 1'b1;
            w_pk_clear = 1'b1;
          end else begin
            w_tmo_run = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Output registers, address counter and inter-byte timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_adress      <= '0;
      r_data_out    <= '0;
      r_write_en    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_tmo_cnt     <= '0;
    end else begin
      r_write_en    <= w_write;
      r_frame_done  <= w_last;
      r_timeout_err <= w_timeout;
      r_tmo_cnt     <= w_tmo_run ? r_tmo_cnt + TMO_W'(1) : '0;
      if (w_write) r_data_out <= w_word;
      if (frame_start)     r_adress <= '0;
      else if (r_write_en) r_adress <= w_adress_inc;
    end
  end

  assign adress      = r_adress;
  assign data_out    = r_data_out;
  assign write_en    = r_write_en;
  assign frame_done  = r_frame_done;
  assign timeout_err = r_timeout_err;
  assign busy        = (r_state == RECEIVE);

endmodule

// File: tb/tb_ram_writer.sv
// Self-checking bench for ram_writer: a 4-word frame, directed scenarios
// with randomized byte values and gaps, checked against a byte-list model.
module tb_ram_writer;

  localparam int RW    = 32;
  localparam int NB    = 128;
  localparam int TMO   = 20;
  localparam int DEPTH = NB / RW;
  localparam int BPW   = RW / 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_ready = 1'b0;
  logic          frame_start = 1'b0;
  logic [AW-1:0] adress;
  logic [RW-1:0] data_out;
  logic          write_en, busy, frame_done, timeout_err;

  ram_writer #(.RAM_WIDTH(RW), .N_BITS(NB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .frame_start (frame_start),
    .adress      (adress),
    .data_out    (data_out),
    .write_en    (write_en),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [RW-1:0] d;
    logic          fd;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  n_tmo = 0;

  // Reference model: a frame is a list of bytes; every BPW bytes form one
  // big-endian word at the next address; the last address ends the frame.
  bit         m_active = 0;
  int         m_addr   = 0;
  logic [7:0] m_buf[$];

  task automatic m_start();
    m_active = 1;
    m_addr   = 0;
    m_buf.delete();
  endtask

  task automatic m_byte(input logic [7:0] b);
    wr_t        w;
    logic [RW-1:0] word;
    if (!m_active) return;
    m_buf.push_back(b);
    if (m_buf.size() == BPW) begin
      word = '0;
      foreach (m_buf[i]) word = (word << 8) | RW'(m_buf[i]);
      w.a  = AW'(m_addr);
      w.d  = word;
      w.fd = (m_addr == DEPTH - 1);
      exp_q.push_back(w);
      m_buf.delete();
      if (m_addr == DEPTH - 1) begin
        m_active = 0;
        m_addr   = 0;
      end else begin
        m_addr = m_addr + 1;
      end
    end
  endtask

  task automatic m_timeout();
    m_buf.delete();
  endtask

  task automatic m_reset();
    m_active = 0;
    m_addr   = 0;
    m_buf.delete();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the rising edge and any write
  // or timeout pulse is logged.
  task automatic tick();
    wr_t w;
    @(posedge clk);
    #1;
    if (write_en || frame_done) begin
      w.a  = adress;
      w.d  = data_out;
      w.fd = frame_done;
      got_q.push_back(w);
    end
    if (timeout_err) n_tmo++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b, input bit fs = 0);
    rx_data     = b;
    rx_ready    = 1'b1;
    frame_start = fs;
    if (fs) m_start();
    m_byte(b);
    tick();
    rx_ready    = 1'b0;
    frame_start = 1'b0;
    rx_data     = 8'($urandom);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    m_start();
    tick();
    frame_start = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_adr%0d", tag, i),  64'(got_q[i].a),  64'(exp_q[i].a));
      check($sformatf("%s_data%0d", tag, i), 64'(got_q[i].d),  64'(exp_q[i].d));
      check($sformatf("%s_fd%0d", tag, i),   64'(got_q[i].fd), 64'(exp_q[i].fd));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #2 rst = 1'b0;
    #10;
    check("rst_adress",   64'(adress),      0);
    check("rst_data",     64'(data_out),    0);
    check("rst_we",       64'(write_en),    0);
    check("rst_busy",     64'(busy),        0);
    check("rst_fd",       64'(frame_done),  0);
    check("rst_tmo",      64'(timeout_err), 0);
    rst = 1'b1;
    idle(2);

    // Single word with 5-cycle gaps; exact write latency and address step.
    start_frame();
    check("t1_busy", 64'(busy),   1);
    check("t1_adr0", 64'(adress), 0);
    send(8'h11); idle(5);
    send(8'h22); idle(5);
    send(8'h33); idle(5);
    send(8'h44);
    check("t1_we_early", 64'(write_en), 0);
    tick();
    check("t1_we",       64'(write_en), 1);
    check("t1_data",     64'(data_out), 64'h11223344);
    check("t1_adr",      64'(adress),   0);
    tick();
    check("t1_we_off",   64'(write_en), 0);
    check("t1_adr_next", 64'(adress),   1);
    compare_writes("t1");

    // Full frame, random gaps including a byte in the word-full cycle.
    start_frame();
    for (int i = 0; i < 16; i++) begin
      send(8'(i));
      if (i == 3)       idle(0);
      else if (i == 7)  idle(1);
      else if (i < 15)  idle($urandom_range(0, 4));
    end
    idle(3);
    compare_writes("t2");
    check("t2_idle",   64'(busy),   0);
    check("t2_adr",    64'(adress), 0);
    send(8'h10);
    idle(4);
    compare_writes("t2_extra");

    // Timeout on a partial word, then a clean word at the same address.
    start_frame();
    send(8'hAA); idle(2);
    send(8'hBB);
    idle(TMO - 1);
    check("t3_tmo_early", 64'(timeout_err), 0);
    idle(1);
    check("t3_tmo_pulse", 64'(timeout_err), 1);
    m_timeout();
    idle(1);
    check("t3_tmo_off",  64'(timeout_err), 0);
    check("t3_busy",     64'(busy),        1);
    check("t3_tmo_once", 64'(n_tmo),       1);
    for (int i = 1; i <= 4; i++) send(8'(i));
    idle(2);
    compare_writes("t3");

    // Byte arriving in the write_en cycle starts the next word.
    for (int i = 0; i < 4; i++) send(8'($urandom));
    tick();
    check("t4_we", 64'(write_en), 1);
    send(8'h55);
    for (int i = 0; i < 3; i++) send(8'($urandom));
    idle(2);
    compare_writes("t4");

    // Restart mid-frame with a simultaneous byte.
    start_frame();
    for (int i = 0; i < 10; i++) begin
      send(8'($urandom));
      idle($urandom_range(0, 2));
    end
    send(8'h99, 1'b1);
    send(8'h98); send(8'h97); send(8'h96);
    idle(2);
    compare_writes("t5");
    check("t5_no_tmo", 64'(n_tmo), 1);

    // Asynchronous reset mid-word.
    send(8'($urandom));
    send(8'($urandom));
    @(posedge clk);
    #4 rst = 1'b0;
    #1;
    m_reset();
    check("t6_adress", 64'(adress),      0);
    check("t6_data",   64'(data_out),    0);
    check("t6_we",     64'(write_en),    0);
    check("t6_busy",   64'(busy),        0);
    check("t6_fd",     64'(frame_done),  0);
    check("t6_tmo",    64'(timeout_err), 0);
    #2 rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send(8'($urandom));
    idle(2);
    compare_writes("t6_ignored");
    start_frame();
    for (int i = 0; i < 4; i++) send(8'($urandom));
    idle(2);
    compare_writes("t6_new");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
